mult_stage2_pipe: RTL

Pipelined final-addition stage of the 8x8 approximate multiplier, directly downstream of the partial-product compression stage (ATC8/ATC4/iCAC). It accepts the redundant pair P7/Q7 and error vectors V1/V2 under a valid/ready handshake and produces the registered 16-bit product through a two-stage pipeline. It has full backpressure and sustains one product per cycle.

---
 rtl/mult_pkg.sv | 21 ++
 rtl/mult_stage2_pipe_slice.sv | 28 ++
 rtl/mult_stage2_pipe.sv | 96 +++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared widths and record types for the approximate 8x8 multiplier pipeline.
package mult_pkg;

  localparam int W_PQ  = 15;
  localparam int W_V1  = 13;
  localparam int W_V2  = 11;
  localparam int W_OUT = 16;

  typedef struct packed {
    logic [W_PQ-1:0] p7;
    logic [W_PQ-1:0] q7;
    logic [W_V1-1:0] v1;
    logic [W_V2-1:0] v2;
  } s1_out_t;

  typedef struct packed {
    logic [W_OUT-1:0] product;
    logic             ovf;
  } s2_out_t;

endpackage

// File: rtl/mult_stage2_pipe_slice.sv
// Generic valid/ready register slice: one entry, full throughput, and the
// ready signal depends only on its own occupancy and the downstream ready.
module pipe_slice #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      out_data  <= in_data;
    end
  end

endmodule

// File: rtl/mult_stage2_pipe.sv
// Final-addition stage of the approximate multiplier: S=P7+Q7 plus optional
// V1/V2 compensation (enabled by macro MULT_APPROX_COMP_EN), two slices deep.
module mult_stage2_pipe
  import mult_pkg::*;
#(
  parameter int W_PQ  = mult_pkg::W_PQ,
  parameter int W_V1  = mult_pkg::W_V1,
  parameter int W_V2  = mult_pkg::W_V2,
  parameter int W_OUT = mult_pkg::W_OUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W_PQ-1:0]  P7,
  input  logic [W_PQ-1:0]  Q7,
  input  logic [W_V1-1:0]  V1,
  input  logic [W_V2-1:0]  V2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W_OUT-1:0] product,
  output logic             out_ovf,
  output logic [15:0]      out_count
);

  s1_out_t            s1_in;
  logic [W_OUT-1:0]   sum_in;
  logic [W_OUT-1:0]   comp_in;
  logic [2*W_OUT-1:0] data_p0;
  logic               vld_p0;
  logic               ready_p1;
  s2_out_t            add_p1;
  s2_out_t            data_p1;
  logic               vld_p1;

  function automatic s2_out_t final_add(input logic [W_OUT-1:0] s,
                                        input logic [W_OUT-1:0] c);
    logic [W_OUT:0] t;
    s2_out_t        r;
    t         = {1'b0, s} + {1'b0, c};
    r.product = t[W_OUT-1:0];
    r.ovf     = t[W_OUT];
    return r;
  endfunction

  assign s1_in  = {P7, Q7, V1, V2};
  assign sum_in = W_OUT'(s1_in.p7) + W_OUT'(s1_in.q7);

`ifdef MULT_APPROX_COMP_EN
  assign comp_in = W_OUT'(s1_in.v1) + W_OUT'(s1_in.v2);
`else
  // Without compensation the error vectors are dropped; product is exact P7+Q7.
  logic unused_err;
  assign comp_in    = '0;
  assign unused_err = ^{s1_in.v1, s1_in.v2};
`endif

  // Stage A: register the redundant sum and the compensation term
  pipe_slice #(.WIDTH(2*W_OUT)) u_stage_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({sum_in, comp_in}),
    .out_valid (vld_p0),
    .out_ready (ready_p1),
    .out_data  (data_p0)
  );

  assign add_p1 = final_add(data_p0[2*W_OUT-1:W_OUT], data_p0[W_OUT-1:0]);

  // Stage B: register the carry-propagated product
  pipe_slice #(.WIDTH($bits(s2_out_t))) u_stage_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (vld_p0),
    .in_ready  (ready_p1),
    .in_data   (add_p1),
    .out_valid (vld_p1),
    .out_ready (out_ready),
    .out_data  (data_p1)
  );

  assign out_valid = vld_p1;
  assign product   = data_p1.product;
  assign out_ovf   = data_p1.ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_count <= '0;
    end else if (vld_p1 && out_ready) begin
      out_count <= out_count + 16'd1;
    end
  end

endmodule
